cos_taylor_acc: RTL and testbench
=================================

# cos_taylor_acc

Parametrised successor to the 10-bit cosine accelerator. It computes cos(x) in fixed point with an iterative Taylor series, and sin(x) when the sine option is compiled in. It sits on the same start/done datapath as its predecessor. Operand width and maximum term count are parameters, the term count is clamped, and the result width is widened so that 1.0 is representable.

## Interface
- W, 10: operand fraction width; x is unsigned Q0.W, range [0,1).
- MAX_TERMS, 8: largest supported series length, ≥1.
- G, 4: guard fraction bits in the internal datapath.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- xBus  input  W  argument x, Q0.W.
- yBus  input  $clog2(MAX_TERMS+1)  number of series terms n.
- mode  input  1  0 = cos, 1 = sin; honoured only with the sine option.
- busy  output  1  high from accepted start through the FINISH edge.
- done  output  1  one-cycle pulse when RBus updates.
- RBus  output  W+1  result, unsigned Q1.W; holds until the next completion.

## Operation
- States: IDLE, SQUARE, MUL, SCALE, FINISH.
- IDLE, start=1: latch x, n_eff and mode.
  - n_eff = n clamped to [1, MAX_TERMS].
  - term ← 1.0 (cos) or x (sin); acc ← term.
  - busy ← 1; go to SQUARE.
- SQUARE: x2 ← x·x; k ← 1. If n_eff==1 go to FINISH, else go to MUL.
- MUL: prod ← term·x2.
- SCALE:
  - term ← prod·coef[mode][k].
  - acc ← acc − term (k odd) or acc + term (k even).
  - k++.
  - Go to FINISH if k==n_eff−1 before increment, else go to MUL.
- FINISH:
  - RBus ← acc rounded half-up to W fraction bits, clamped to [0, 2^(W+1)−1].
  - done ← 1 for this cycle; busy ← 0; go to IDLE.
- Coefficients, Q0.(W+G), truncated:
  - cos: 1/((2k−1)(2k)).
  - sin: 1/((2k)(2k+1)).
- Arithmetic:
  - Internal values are signed, W+G fraction bits plus 2 integer bits.
  - Every product is truncated (floor) back to W+G fraction bits.
- start while busy: ignored; latched operands are unaffected.
- xBus, yBus and mode are don't-care outside the start-sample edge.

## Timing
- Reset values: busy=0, done=0, RBus=0, state=IDLE. All internal registers are cleared.
- Latency: done is high in the cycle following edge 2·n_eff after the start-sample edge.
  - n_eff=1 → 2 cycles.
  - n_eff=8 → 16 cycles.
- Back-to-back: start may be high in the same cycle done is high. It is accepted at the next edge, because the FSM is then in IDLE.
- Reset mid-operation aborts immediately. Outputs return to reset values and no done is produced. The first start after release is accepted normally.
- yBus=0 behaves as n=1. yBus>MAX_TERMS behaves as MAX_TERMS.

## Configuration
- TRIG_SIN_MODE_EN
  - Defined: mode selects cos or sin; the coefficient ROM holds both tables.
  - Undefined: mode is ignored and forced to cos; only the cos table is built.
  - The port list is identical either way.

## Structure
- Package cos_taylor_pkg contains:
  - state enum.
  - TERM_W = $clog2(MAX_TERMS+1).
  - Function coef(mode, k, W, G) that generates the ROM constants at elaboration.
  - Constant ONE_Q = 1<<(W+G).
- One sub-module, cos_taylor_mulq: signed fractional multiplier with floor truncation to W+G fraction bits. It is instanced once and time-shared between SQUARE, MUL and SCALE.

## Test plan
- Reset held, then released; no start → busy=0, done=0, RBus=0.
- x=0x100 (0.25), n=2, cos → done 4 cycles after start; RBus=992 (0x3E0).
- x=0x191, n=1, cos → done after 2 cycles; RBus=1024.
- x=0x007, n=1 → RBus=1024. Then:
  - x=0, n=0 → RBus=1024, done after 2 cycles.
  - n=15 with MAX_TERMS=8 → latency 16.
- Sine option compiled in, x=0x100, n=1, mode=1 → RBus=256. Repeat with the option undefined → RBus=1024.
- Abort and busy handling:
  - start, then rst pulsed during MUL → no done; outputs 0.
  - Next start (x=0x100, n=2) → RBus=992.
  - start re-asserted while busy → ignored; a single done pulse.

Source files
------------

// File: rtl/cos_taylor_pkg.sv
// -----------------------------------------------------------------------------
// cos_taylor_pkg
// Shared definitions for the iterative Taylor-series cosine/sine accelerator:
//   - state_t   : controller states
//   - TERM_W    : width of the term-count operand for the default MAX_TERMS
//   - ONE_Q     : fixed-point 1.0 for the default fraction width (W+G bits)
//   - one_q()   : fixed-point 1.0 for an arbitrary W/G pair
//   - coef()    : elaboration-time generator for the series coefficient ROM
// -----------------------------------------------------------------------------
package cos_taylor_pkg;

    localparam int W_DEF         = 10;
    localparam int MAX_TERMS_DEF = 8;
    localparam int G_DEF         = 4;

    localparam int     TERM_W = $clog2(MAX_TERMS_DEF + 1);
    localparam longint ONE_Q  = longint'(1) << (W_DEF + G_DEF);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SQUARE = 3'd1,
        MUL    = 3'd2,
        SCALE  = 3'd3,
        FINISH = 3'd4
    } state_t;

    function automatic longint one_q(input int w, input int g);
        return longint'(1) << (w + g);
    endfunction

    // Truncated Q0.(w+g) coefficient for step k of the recurrence.
    // cos: 1/((2k-1)(2k)), sin: 1/((2k)(2k+1)). k<1 has no meaning and gives 0.
    function automatic longint coef(input logic sel_sin, input int k,
                                    input int w, input int g);
        longint den;
        if (k < 1) begin
            den = 64'sd0;
        end else if (sel_sin) begin
            den = longint'(2 * k) * longint'(2 * k + 1);
        end else begin
            den = longint'(2 * k - 1) * longint'(2 * k);
        end
        if (den == 64'sd0) begin
            return 64'sd0;
        end else begin
            return one_q(w, g) / den;
        end
    endfunction

endpackage

// File: rtl/cos_taylor_acc_mulq.sv
// -----------------------------------------------------------------------------
// cos_taylor_mulq
// Signed fractional multiplier. Both operands and the result carry FW fraction
// bits; the full-width product is floored (arithmetic shift) back to FW
// fraction bits and truncated to DW bits. Purely combinational.
// Ports:
//   a, b : signed DW-bit operands
//   p    : signed DW-bit product, floor((a*b) / 2^FW)
// -----------------------------------------------------------------------------
module cos_taylor_mulq
    import cos_taylor_pkg::*;
#(
    parameter int DW = 16,
    parameter int FW = 14
) (
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] p
);

    logic signed [2*DW-1:0] a_ext_s;
    logic signed [2*DW-1:0] b_ext_s;
    logic signed [2*DW-1:0] full_s;

    assign a_ext_s = {{DW{a[DW-1]}}, a};
    assign b_ext_s = {{DW{b[DW-1]}}, b};
    assign full_s  = a_ext_s * b_ext_s;
    // Arithmetic shift gives floor for negative products as well.
    assign p       = DW'(full_s >>> FW);

endmodule

// File: rtl/cos_taylor_acc.sv
// -----------------------------------------------------------------------------
// cos_taylor_acc
// Iterative Taylor-series accelerator computing cos(x) (and sin(x) when the
// TRIG_SIN_MODE_EN macro is defined) for x in [0,1), unsigned Q0.W input,
// unsigned Q1.W result. One shared multiplier is time-shared between the
// SQUARE, MUL and SCALE states; each extra series term costs two cycles.
// Compile-time option:
//   TRIG_SIN_MODE_EN : when defined, mode selects sin; otherwise mode is
//                      ignored and only the cosine coefficient table exists.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : request, sampled only while idle
//   xBus  : argument x, Q0.W
//   yBus  : requested term count n (clamped to [1, MAX_TERMS])
//   mode  : 0 = cos, 1 = sin (sine option only)
//   busy  : high from accepted start through the completion edge
//   done  : one-cycle pulse when RBus updates
//   RBus  : result, Q1.W, held until the next completion
// -----------------------------------------------------------------------------
module cos_taylor_acc
    import cos_taylor_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int G         = G_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [W-1:0]                     xBus,
    input  logic [$clog2(MAX_TERMS+1)-1:0]   yBus,
    input  logic                             mode,
    output logic                             busy,
    output logic                             done,
    output logic [W:0]                       RBus
);

    localparam int FW    = W + G;
    localparam int DW    = FW + 2;
    localparam int TW    = $clog2(MAX_TERMS + 1);
    localparam int ROM_N = 1 << TW;

    localparam logic signed [DW-1:0] ONE      = DW'(one_q(W, G));
    localparam logic signed [DW:0]   RND_HALF = (DW+1)'(1 << (G - 1));
    localparam logic signed [DW:0]   R_MAX    = (DW+1)'((1 << (W + 1)) - 1);

    state_t state_r;
    state_t state_nx;

    logic signed [DW-1:0] x_r;
    logic signed [DW-1:0] x2_r;
    logic signed [DW-1:0] term_r;
    logic signed [DW-1:0] prod_r;
    logic signed [DW-1:0] acc_r;
    logic [TW-1:0]        k_r;
    logic [TW-1:0]        n_r;
    logic                 mode_r;

    logic [TW-1:0]        n_eff_s;
    logic                 mode_s;
    logic signed [DW-1:0] x_in_s;
    logic signed [DW-1:0] coef_s;
    logic signed [DW-1:0] mul_a_s;
    logic signed [DW-1:0] mul_b_s;
    logic signed [DW-1:0] mul_p_s;
    logic signed [DW:0]   sum_s;
    logic signed [DW:0]   shr_s;
    logic [W:0]           rnd_s;

    // Coefficient ROMs, indexed directly by k; entry 0 is never addressed.
    logic signed [DW-1:0] cos_rom [ROM_N];
    for (genvar i = 0; i < ROM_N; i++) begin : g_cos_rom
        assign cos_rom[i] = DW'(coef(1'b0, i, W, G));
    end

`ifdef TRIG_SIN_MODE_EN
    logic signed [DW-1:0] sin_rom [ROM_N];
    for (genvar i = 0; i < ROM_N; i++) begin : g_sin_rom
        assign sin_rom[i] = DW'(coef(1'b1, i, W, G));
    end
    assign mode_s = mode;
    assign coef_s = mode_r ? sin_rom[k_r] : cos_rom[k_r];
`else
    // Without the sine table mode is forced to cos; the AND keeps the port
    // referenced so the port list stays identical across builds.
    assign mode_s = mode & 1'b0;
    assign coef_s = mode_r ? {DW{1'b0}} : cos_rom[k_r];
`endif

    // x widened to the internal signed Q2.(W+G) format.
    assign x_in_s = {2'b00, xBus, {G{1'b0}}};

    // Clamp the requested term count to [1, MAX_TERMS].
    always_comb begin
        if (yBus == {TW{1'b0}}) begin
            n_eff_s = TW'(1);
        end else if (yBus > TW'(MAX_TERMS)) begin
            n_eff_s = TW'(MAX_TERMS);
        end else begin
            n_eff_s = yBus;
        end
    end

    // Route operands into the single shared multiplier per state.
    always_comb begin
        mul_a_s = {DW{1'b0}};
        mul_b_s = {DW{1'b0}};
        case (state_r)
            SQUARE: begin
                mul_a_s = x_r;
                mul_b_s = x_r;
            end
            MUL: begin
                mul_a_s = term_r;
                mul_b_s = x2_r;
            end
            SCALE: begin
                mul_a_s = prod_r;
                mul_b_s = coef_s;
            end
            default: begin
                mul_a_s = {DW{1'b0}};
                mul_b_s = {DW{1'b0}};
            end
        endcase
    end

    cos_taylor_mulq #(
        .DW (DW),
        .FW (FW)
    ) u_mulq (
        .a (mul_a_s),
        .b (mul_b_s),
        .p (mul_p_s)
    );

    // Round half-up to W fraction bits, then clamp into the Q1.W output range.
    assign sum_s = {acc_r[DW-1], acc_r} + RND_HALF;
    assign shr_s = sum_s >>> G;

    // Result saturation.
    always_comb begin
        if (shr_s[DW]) begin
            rnd_s = {(W+1){1'b0}};
        end else if (shr_s > R_MAX) begin
            rnd_s = {(W+1){1'b1}};
        end else begin
            rnd_s = shr_s[W:0];
        end
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic. k counts completed-term steps; the last SCALE is the
    // one that processes k == n_eff-1.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx = SQUARE;
                end else begin
                    state_nx = IDLE;
                end
            end
            SQUARE: begin
                if (n_r == TW'(1)) begin
                    state_nx = FINISH;
                end else begin
                    state_nx = MUL;
                end
            end
            MUL: begin
                state_nx = SCALE;
            end
            SCALE: begin
                if (k_r == (n_r - TW'(1))) begin
                    state_nx = FINISH;
                end else begin
                    state_nx = MUL;
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r    <= {DW{1'b0}};
            x2_r   <= {DW{1'b0}};
            term_r <= {DW{1'b0}};
            prod_r <= {DW{1'b0}};
            acc_r  <= {DW{1'b0}};
            k_r    <= {TW{1'b0}};
            n_r    <= {TW{1'b0}};
            mode_r <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            RBus   <= {(W+1){1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        x_r    <= x_in_s;
                        n_r    <= n_eff_s;
                        mode_r <= mode_s;
                        term_r <= mode_s ? x_in_s : ONE;
                        acc_r  <= mode_s ? x_in_s : ONE;
                        busy   <= 1'b1;
                    end
                end
                SQUARE: begin
                    x2_r <= mul_p_s;
                    k_r  <= TW'(1);
                end
                MUL: begin
                    prod_r <= mul_p_s;
                end
                SCALE: begin
                    term_r <= mul_p_s;
                    acc_r  <= k_r[0] ? (acc_r - mul_p_s) : (acc_r + mul_p_s);
                    k_r    <= k_r + TW'(1);
                end
                FINISH: begin
                    RBus <= rnd_s;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cos_taylor_acc.sv
// -----------------------------------------------------------------------------
// tb_cos_taylor_acc
// Directed bench for cos_taylor_acc at default parameters (W=10, MAX_TERMS=8,
// G=4). A behavioural model computes the series with plain integer arithmetic
// and tracks when done/busy must appear; a negedge process compares the DUT
// to it every cycle. Directed runs additionally pin literal results/latencies.
// -----------------------------------------------------------------------------
module tb_cos_taylor_acc;
    import cos_taylor_pkg::*;

    localparam int FB = W_DEF + G_DEF;

    logic              clk;
    logic              rst;
    logic              start;
    logic [W_DEF-1:0]  xBus;
    logic [TERM_W-1:0] yBus;
    logic              mode;
    logic              busy;
    logic              done;
    logic [W_DEF:0]    RBus;

    int total;
    int bad;

    cos_taylor_acc dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .xBus  (xBus),
        .yBus  (yBus),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .RBus  (RBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected result straight from the series definition.
    function automatic longint model_r(input int x, input int n, input bit m);
        longint xq, x2, term, acc, r, c;
        int     ne;
        bit     sn;
`ifdef TRIG_SIN_MODE_EN
        sn = m;
`else
        sn = 1'b0 & m;
`endif
        ne = (n == 0) ? 1 : ((n > MAX_TERMS_DEF) ? MAX_TERMS_DEF : n);
        xq = longint'(x) << G_DEF;
        x2 = (xq * xq) >>> FB;
        term = sn ? xq : ONE_Q;
        acc = term;
        for (int k = 1; k < ne; k++) begin
            c = sn ? ONE_Q / ((2 * k) * (2 * k + 1)) : ONE_Q / ((2 * k - 1) * (2 * k));
            term = (((term * x2) >>> FB) * c) >>> FB;
            acc = (k % 2 == 1) ? acc - term : acc + term;
        end
        r = (acc + (longint'(1) << (G_DEF - 1))) >>> G_DEF;
        if (r < 0) r = 0;
        if (r > 2047) r = 2047;
        return r;
    endfunction

    // Timing/result model: a start accepted while idle finishes 2*n_eff edges later.
    logic   m_busy;
    logic   m_done;
    longint m_r;
    longint m_pending;
    int     m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy    <= 1'b0;
            m_done    <= 1'b0;
            m_r       <= 0;
            m_pending <= 0;
            m_left    <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_r    <= m_pending;
                end
                m_left <= m_left - 1;
            end else if (start) begin
                m_busy    <= 1'b1;
                m_left    <= 2 * ((yBus == 0) ? 1 : ((int'(yBus) > MAX_TERMS_DEF) ? MAX_TERMS_DEF : int'(yBus)));
                m_pending <= model_r(int'(xBus), int'(yBus), mode);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_busy", longint'(busy), longint'(m_busy));
            check("cyc_done", longint'(done), longint'(m_done));
            check("cyc_rbus", longint'(RBus), m_r);
        end
    end

    task automatic run(input logic [W_DEF-1:0] x, input logic [TERM_W-1:0] n,
                       input bit m, input int exp_r, input int exp_lat, input string nm);
        int lat;
        @(negedge clk);
        xBus  = x;
        yBus  = n;
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        xBus  = W_DEF'($urandom);
        yBus  = TERM_W'($urandom);
        mode  = 1'($urandom);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, "_lat"}, longint'(lat), longint'(exp_lat));
        if (exp_r >= 0) check({nm, "_r"}, longint'(RBus), longint'(exp_r));
    endtask

    initial begin
        int     dones;
        int     pulses;
        longint exp_v;
        total = 0;
        bad   = 0;
        start = 1'b0;
        xBus  = '0;
        yBus  = '0;
        mode  = 1'b0;
        rst   = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", longint'(busy), 0);
        check("reset_done", longint'(done), 0);
        check("reset_rbus", longint'(RBus), 0);

        // Model pinned by hand-computed values.
        check("model_q25_n2", model_r(256, 2, 1'b0), 992);
        check("model_n1", model_r(401, 1, 1'b0), 1024);

        run(10'h100, 4'd2,  1'b0, 992,  4,  "cos_q25_n2");
        run(10'h191, 4'd1,  1'b0, 1024, 2,  "cos_n1");
        run(10'h007, 4'd1,  1'b0, 1024, 2,  "cos_small_n1");
        run(10'h000, 4'd0,  1'b0, 1024, 2,  "n0_clamp");
        run(10'h000, 4'd15, 1'b0, 1024, 16, "n15_clamp");
`ifdef TRIG_SIN_MODE_EN
        run(10'h100, 4'd1,  1'b1, 256,  2,  "sin_n1");
        run(10'h3FF, 4'd4,  1'b1, -1,   8,  "sin_full_n4");
`else
        run(10'h100, 4'd1,  1'b1, 1024, 2,  "sin_off_n1");
`endif
        run(10'h3FF, 4'd8,  1'b0, -1,   16, "cos_full_n8");
        run(10'h200, 4'd3,  1'b0, -1,   6,  "cos_half_n3");

        // Reset during MUL aborts without a done pulse.
        @(negedge clk);
        xBus  = 10'h191;
        yBus  = 4'd4;
        mode  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy_before", longint'(busy), 1);
        rst = 1'b1;
        #1;
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        check("abort_rbus", longint'(RBus), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort_no_done", longint'(dones), 0);
        run(10'h100, 4'd2, 1'b0, 992, 4, "after_abort");

        // start re-asserted while busy must be ignored.
        @(negedge clk);
        xBus  = 10'h100;
        yBus  = 4'd3;
        mode  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        exp_v  = model_r(256, 3, 1'b0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (i >= 1 && i <= 3) begin
                start = 1'b1;
                xBus  = 10'h3FF;
                yBus  = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                check("busy_ignore_r", longint'(RBus), exp_v);
            end
        end
        start = 1'b0;
        check("busy_ignore_pulses", longint'(pulses), 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
